controle_fechadura: RTL and testbench
=====================================

# controle_fechadura

Sequencing controller for the serial-code door lock: it frames a code-entry attempt, shifts in a fixed-length serial code, and compares it against a stored password. It counts consecutive failures and enforces a lockout after too many. While the door is open it allows the password to be reprogrammed. It sits between the keypad/serial front end (start, bit strobes) and the door actuator/status LEDs (aberta, erro, bloqueada).

## Interface
- CODE_LEN, 6, code length in bits (2..16)
- DEFAULT_CODE, 6'b101100, password loaded at reset (CODE_LEN bits)
- MAX_FAIL, 3, consecutive failures that trigger lockout (1..7)
- OPEN_CYCLES, 8, cycles the door stays open (1..255)
- LOCK_CYCLES, 16, lockout duration in cycles (1..255)
- TIMEOUT, 10, max idle cycles between bits during entry (1..255)
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin attempt; sampled only in IDLE
- bit_valid  in  1  strobe: bit_in is valid this cycle
- bit_in  in  1  serial code bit, MSB first
- prog  in  1  request password reprogramming; sampled only in ABERTA
- aberta  out  1  door open
- erro  out  1  wrong code / lockout indication
- bloqueada  out  1  lockout active
- busy  out  1  controller not in IDLE
- falhas  out  3  current consecutive-failure count

## Operation
- States: IDLE, RECEBE, VERIFICA, ABERTA, PROGRAMA, ERRO, BLOQUEIO.
- Registers: shift register sr[CODE_LEN], bit counter cnt, 8-bit timer tmr, password senha[CODE_LEN], falhas[3].
- Outputs are Moore, decoded from the state register only:
  - aberta=1 in ABERTA and PROGRAMA.
  - erro=1 in ERRO and BLOQUEIO.
  - bloqueada=1 in BLOQUEIO.
  - busy=1 in any state except IDLE.
  - falhas is the register value.
- IDLE: bit_valid and prog are ignored. start=1 moves to RECEBE and clears sr, cnt, and tmr.
- RECEBE:
  - On bit_valid=1: sr <= {sr[CODE_LEN-2:0], bit_in}, cnt++, tmr cleared.
  - When the accepted bit is the CODE_LEN-th bit, go to VERIFICA.
  - On cycles without bit_valid, tmr++. When tmr reaches TIMEOUT, the attempt is scored as a mismatch (same path as VERIFICA mismatch).
  - start is ignored.
- VERIFICA (1 cycle):
  - sr==senha: falhas <= 0, go to ABERTA, tmr cleared.
  - Mismatch: falhas++. If the new value equals MAX_FAIL, go to BLOQUEIO (tmr cleared); otherwise go to ERRO.
- ABERTA:
  - tmr++ each cycle; after OPEN_CYCLES cycles in ABERTA, go to IDLE.
  - prog=1 has priority over expiry and moves to PROGRAMA, clearing sr, cnt, and tmr.
- PROGRAMA:
  - Shifts bits exactly as RECEBE does, with the same TIMEOUT rule.
  - After CODE_LEN bits: senha <= new code, go to IDLE.
  - On timeout: go to IDLE with senha unchanged and no failure counted.
- ERRO: lasts 1 cycle, then IDLE.
- BLOQUEIO:
  - Lasts LOCK_CYCLES cycles. start, bit_valid, and prog are ignored.
  - On exit: falhas <= 0, go to IDLE.
- falhas saturates at MAX_FAIL and never wraps.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, senha=DEFAULT_CODE, falhas=0, sr=0, cnt=0, tmr=0.
  - Outputs aberta=0, erro=0, bloqueada=0, busy=0.
- Reset mid-operation aborts immediately, including mid-PROGRAMA; the password reverts to DEFAULT_CODE.
- Reset deassertion takes effect on the next rising clk edge.
- start sampled at edge t: busy=1 from t.
- Last code bit sampled at edge k:
  - VERIFICA holds during cycle k..k+1.
  - aberta or erro rises after edge k+1 (2-edge latency from the last bit).
- aberta stays high for exactly OPEN_CYCLES cycles with no prog. busy falls on the same edge as aberta.
- erro in ERRO is a single-cycle pulse. In BLOQUEIO, erro=bloqueada=1 for exactly LOCK_CYCLES cycles.
- Timeout: TIMEOUT consecutive cycles without bit_valid in RECEBE. The transition fires on the edge where tmr==TIMEOUT and bit_valid=0.
- A bit_valid on the same edge as the timeout wins: the bit is accepted and tmr is cleared.
- prog and OPEN_CYCLES expiry on the same edge: prog wins.
- A new attempt may start on the cycle after returning to IDLE.

## Test plan
- **Correct code:** reset; start; bits 1,0,1,1,0,0 on consecutive cycles.
  - aberta=1 two edges after the last bit, for 8 cycles.
  - falhas=0, erro never 1.
- **Wrong code:** start; bits 1,0,1,1,0,1.
  - One-cycle erro pulse, falhas=1, aberta stays 0.
- **Lockout:** three wrong attempts back-to-back.
  - Third verify leads to bloqueada=erro=1 for 16 cycles.
  - A start during lockout is ignored.
  - Afterwards falhas=0 and a correct code opens.
- **Reprogram:** correct code; prog=1 in the 2nd aberta cycle; bits 0,1,1,0,1,0.
  - aberta held through PROGRAMA, then IDLE.
  - 101100 now gives erro; 011010 opens.
- **Timeout:** start; bits 1,0 then 10 idle cycles.
  - Mismatch path taken: erro pulse, falhas=1.
  - A bit_valid on the 10th idle edge instead keeps RECEBE.
- **Reset mid-reprogram:** rst=0 after 3 new bits.
  - All outputs 0 immediately.
  - 101100 opens after release.

Source files
------------

// File: rtl/controle_fechadura.sv
// controle_fechadura
// Sequencing controller for the serial-code door lock. It frames a code-entry
// attempt, shifts in a fixed-length serial code (MSB first), compares it with
// the stored password, counts consecutive failures, enforces a lockout after
// too many failures, and lets the password be reprogrammed while the door is open.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous, active-low reset
//   start      begin an attempt (only looked at in IDLE)
//   bit_valid  strobe, bit_in is valid this cycle
//   bit_in     serial code bit, MSB first
//   prog       request password reprogramming (only looked at in ABERTA)
//   aberta     door open (ABERTA and PROGRAMA)
//   erro       wrong code / lockout indication (ERRO and BLOQUEIO)
//   bloqueada  lockout active
//   busy       controller not in IDLE
//   falhas     current consecutive-failure count

module controle_fechadura #(
    parameter int                  CODE_LEN     = 6,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE = 6'b101100,
    parameter int                  MAX_FAIL     = 3,
    parameter int                  OPEN_CYCLES  = 8,
    parameter int                  LOCK_CYCLES  = 16,
    parameter int                  TIMEOUT      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       prog,
    output logic       aberta,
    output logic       erro,
    output logic       bloqueada,
    output logic       busy,
    output logic [2:0] falhas
);

    localparam int CNT_W = $clog2(CODE_LEN + 1);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CODE_LEN - 1);
    localparam logic [7:0]       TMO_V     = 8'(TIMEOUT);
    localparam logic [7:0]       OPEN_LAST = 8'(OPEN_CYCLES - 1);
    localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CYCLES - 1);
    localparam logic [2:0]       MAX_V     = 3'(MAX_FAIL);

    typedef enum logic [2:0] {
        IDLE,
        RECEBE,
        VERIFICA,
        ABERTA,
        PROGRAMA,
        ERRO,
        BLOQUEIO
    } state_t;

    state_t              state, state_next;
    logic [CODE_LEN-1:0] sr, sr_next;
    logic [CODE_LEN-1:0] senha, senha_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [7:0]          tmr, tmr_next;
    logic [2:0]          falhas_q, falhas_next;

    logic [CODE_LEN-1:0] shifted;
    logic [2:0]          falhas_inc;
    state_t              fail_state;

    // Shift register contents once the current bit is accepted.
    assign shifted = {sr[CODE_LEN-2:0], bit_in};

    // A failed attempt (wrong code or entry timeout) bumps the saturating
    // failure counter; reaching the limit sends us to lockout instead of ERRO.
    assign falhas_inc = (falhas_q == MAX_V) ? falhas_q : falhas_q + 3'd1;
    assign fail_state = (falhas_inc == MAX_V) ? BLOQUEIO : ERRO;

    // All registers: reset restores the factory password and clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sr       <= '0;
            senha    <= DEFAULT_CODE;
            cnt      <= '0;
            tmr      <= '0;
            falhas_q <= '0;
        end else begin
            state    <= state_next;
            sr       <= sr_next;
            senha    <= senha_next;
            cnt      <= cnt_next;
            tmr      <= tmr_next;
            falhas_q <= falhas_next;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_next  = state;
        sr_next     = sr;
        senha_next  = senha;
        cnt_next    = cnt;
        tmr_next    = tmr;
        falhas_next = falhas_q;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RECEBE;
                    sr_next    = '0;
                    cnt_next   = '0;
                    tmr_next   = '0;
                end
            end

            // Code entry and password programming share the shifting and the
            // inactivity timer; a bit on the timeout edge still wins.
            RECEBE, PROGRAMA: begin
                if (bit_valid) begin
                    sr_next  = shifted;
                    cnt_next = cnt + 1'b1;
                    tmr_next = '0;
                    if (cnt == LAST_BIT) begin
                        if (state == RECEBE) begin
                            state_next = VERIFICA;
                        end else begin
                            senha_next = shifted;
                            state_next = IDLE;
                        end
                    end
                end else if (tmr == TMO_V) begin
                    tmr_next = '0;
                    if (state == RECEBE) begin
                        falhas_next = falhas_inc;
                        state_next  = fail_state;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    tmr_next = tmr + 8'd1;
                end
            end

            VERIFICA: begin
                tmr_next = '0;
                if (sr == senha) begin
                    falhas_next = '0;
                    state_next  = ABERTA;
                end else begin
                    falhas_next = falhas_inc;
                    state_next  = fail_state;
                end
            end

            // prog takes priority over the open-time expiry.
            ABERTA: begin
                if (prog) begin
                    state_next = PROGRAMA;
                    sr_next    = '0;
                    cnt_next   = '0;
                    tmr_next   = '0;
                end else if (tmr == OPEN_LAST) begin
                    state_next = IDLE;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr + 8'd1;
                end
            end

            ERRO: begin
                state_next = IDLE;
            end

            BLOQUEIO: begin
                if (tmr == LOCK_LAST) begin
                    state_next  = IDLE;
                    tmr_next    = '0;
                    falhas_next = '0;
                end else begin
                    tmr_next = tmr + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register only.
    assign aberta    = (state == ABERTA) || (state == PROGRAMA);
    assign erro      = (state == ERRO) || (state == BLOQUEIO);
    assign bloqueada = (state == BLOQUEIO);
    assign busy      = (state != IDLE);
    assign falhas    = falhas_q;

endmodule

// File: tb/tb_controle_fechadura.sv
// tb_controle_fechadura
// Self-checking bench for controle_fechadura with default parameters
// (6-bit code 101100, 3 failures to lockout, 8 open cycles, 16 lockout cycles,
// timeout 10). Each driven cycle pushes the expected post-edge output vector
// {aberta, erro, bloqueada, busy, falhas} into a scoreboard queue; a monitor
// pops and compares shortly after every rising edge.

module tb_controle_fechadura;

    logic       clk;
    logic       rst;
    logic       start;
    logic       bit_valid;
    logic       bit_in;
    logic       prog;
    logic       aberta;
    logic       erro;
    logic       bloqueada;
    logic       busy;
    logic [2:0] falhas;

    typedef enum int {S_IDLE, S_RECEBE, S_VERIFICA, S_ABERTA, S_PROGRAMA, S_ERRO, S_BLOQUEIO} st_e;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } sb_t;

    sb_t   sb[$];
    int    total_cnt = 0;
    int    bad_cnt   = 0;
    int    step      = 0;
    string phase     = "init";

    controle_fechadura dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .prog      (prog),
        .aberta    (aberta),
        .erro      (erro),
        .bloqueada (bloqueada),
        .busy      (busy),
        .falhas    (falhas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected output vector for a given controller state and failure count.
    function automatic logic [6:0] expVec(input st_e st, input int f);
        logic a, e, b, bz;
        a  = (st == S_ABERTA) || (st == S_PROGRAMA);
        e  = (st == S_ERRO) || (st == S_BLOQUEIO);
        b  = (st == S_BLOQUEIO);
        bz = (st != S_IDLE);
        return {a, e, b, bz, 3'(f)};
    endfunction

    // Drive one cycle of inputs and record what the outputs must be after the edge.
    task automatic applyStimulus(input logic s, input logic bv, input logic bi, input logic p,
                                 input st_e st, input int f);
        sb_t e;
        start     = s;
        bit_valid = bv;
        bit_in    = bi;
        prog      = p;
        step++;
        e.tag = $sformatf("%s#%0d", phase, step);
        e.exp = expVec(st, f);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        prog      = 1'b0;
    endtask

    // Monitor: compare the oldest expectation against the settled outputs.
    always @(posedge clk) begin
        sb_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.tag, {25'd0, aberta, erro, bloqueada, busy, falhas}, {25'd0, e.exp});
        end
    end

    task automatic idleCycle(input st_e st, input int f);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, st, f);
    endtask

    task automatic sendBits(input logic [5:0] code, input int n, input st_e mid, input st_e last, input int f);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, code[5-i], 1'b0, (i == n - 1) ? last : mid, f);
        end
    endtask

    // start plus a full 6-bit code, ending in VERIFICA.
    task automatic runCode(input logic [5:0] code, input int f);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, S_RECEBE, f);
        sendBits(code, 6, S_RECEBE, S_VERIFICA, f);
    endtask

    // Door open for exactly 8 cycles after VERIFICA, then IDLE.
    task automatic expectOpen();
        for (int i = 0; i < 8; i++) idleCycle(S_ABERTA, 0);
        idleCycle(S_IDLE, 0);
    endtask

    // One-cycle erro pulse with the new failure count, then IDLE.
    task automatic expectErr(input int fnew);
        idleCycle(S_ERRO, fnew);
        idleCycle(S_IDLE, fnew);
    endtask

    // Asynchronous reset in the middle of a cycle, then release.
    task automatic pulseReset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput(tag, {25'd0, aberta, erro, bloqueada, busy, falhas}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        prog      = 1'b0;
        #1;
        checkOutput("reset", {25'd0, aberta, erro, bloqueada, busy, falhas}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Correct code opens for 8 cycles.
        phase = "ok";
        idleCycle(S_IDLE, 0);
        runCode(6'b101100, 0);
        expectOpen();

        // Wrong code gives one erro pulse and one failure.
        phase = "wrong";
        runCode(6'b101101, 0);
        expectErr(1);

        // Lockout after three wrong attempts from a clean count.
        pulseReset("reset_pre_lock");
        phase = "lock";
        runCode(6'b000000, 0);
        expectErr(1);
        runCode(6'b111111, 1);
        expectErr(2);
        runCode(6'b101101, 2);
        idleCycle(S_BLOQUEIO, 3);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(i == 3, i == 5, 1'b1, i == 7, S_BLOQUEIO, 3);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, S_IDLE, 0);
        runCode(6'b101100, 0);
        expectOpen();

        // Entry timeout is scored as a wrong code.
        phase = "tmo";
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, S_RECEBE, 0);
        sendBits(6'b100000, 2, S_RECEBE, S_RECEBE, 0);
        for (int i = 0; i < 10; i++) idleCycle(S_RECEBE, 0);
        expectErr(1);

        // A bit on the timeout edge is accepted and the entry continues.
        phase = "tmo_bit";
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, S_RECEBE, 1);
        sendBits(6'b100000, 2, S_RECEBE, S_RECEBE, 1);
        for (int i = 0; i < 10; i++) idleCycle(S_RECEBE, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, S_RECEBE, 1);
        sendBits(6'b100000, 3, S_RECEBE, S_VERIFICA, 1);
        expectOpen();

        // Reprogram to 011010 from the second open cycle.
        phase = "prog";
        runCode(6'b101100, 0);
        idleCycle(S_ABERTA, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, S_PROGRAMA, 0);
        sendBits(6'b011010, 6, S_PROGRAMA, S_IDLE, 0);
        runCode(6'b101100, 0);
        expectErr(1);
        runCode(6'b011010, 1);
        expectOpen();

        // Reset in the middle of reprogramming restores the default password.
        phase = "rst_prog";
        runCode(6'b011010, 0);
        idleCycle(S_ABERTA, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, S_PROGRAMA, 0);
        sendBits(6'b110000, 3, S_PROGRAMA, S_PROGRAMA, 0);
        pulseReset("reset_mid_prog");
        phase = "after_rst";
        idleCycle(S_IDLE, 0);
        runCode(6'b101100, 0);
        expectOpen();

        @(negedge clk);
        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
